// File: rtl/n64_joybus_phy.sv
// N64 Joybus physical layer: decodes sub-bit-sampled DQ into an RX byte stream
// and serialises a TX byte stream onto the open-drain DQ line, both on the console SI clock.
`timescale 1ns/1ps
module n64_joybus_phy #(
  parameter int unsigned RX_FIFO_DEPTH = 16,
  parameter int unsigned TX_FIFO_DEPTH = 16,
  parameter int unsigned TX_SUB_BITS   = 8,
  parameter int unsigned TX_ONE_LOW    = 2,
  parameter int unsigned TX_ZERO_LOW   = 6,
  parameter int unsigned RX_THRESHOLD  = 4,
  parameter int unsigned RX_STOP       = 15,
  parameter int unsigned RX_TIMEOUT    = 31
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       n64_reset,
  input  logic       n64_si_clk,
  input  logic       si_dq_in,
  output logic       si_dq_oe,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  input  logic       rx_ready,
  output logic       rx_stop,
  output logic       rx_timeout,
  output logic       rx_overflow,
  input  logic       rx_overflow_clear,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  input  logic       tx_start,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int unsigned RX_AW  = $clog2(RX_FIFO_DEPTH);
  localparam int unsigned RX_CW  = RX_AW + 1;
  localparam int unsigned TX_AW  = $clog2(TX_FIFO_DEPTH);
  localparam int unsigned TX_CW  = TX_AW + 1;
  localparam int unsigned CNT_W  = $clog2(RX_TIMEOUT + 1);
  localparam int unsigned TSUB_W = $clog2(TX_SUB_BITS + 1);

  typedef enum logic [1:0] {S_IDLE, S_BYTE, S_STOP} tx_state_t;

  // Synchronisers and SI clock edge detection
  logic [1:0] nrst_sync;
  logic [1:0] sck_sync;
  logic       sck_d;
  logic       dq_r;
  logic       con_run;
  logic       si_rise;
  logic       si_fall;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      nrst_sync <= '0;
      sck_sync  <= '0;
      sck_d     <= 1'b0;
      dq_r      <= 1'b1;
    end else begin
      nrst_sync <= {nrst_sync[0], n64_reset};
      sck_sync  <= {sck_sync[0], n64_si_clk};
      sck_d     <= sck_sync[1];
      dq_r      <= si_dq_in;
    end
  end

  assign con_run = nrst_sync[1];
  assign si_rise = con_run & sck_sync[1] & ~sck_d;
  assign si_fall = con_run & ~sck_sync[1] & sck_d;

  // RX bit decoder
  logic             dq_last;
  logic [CNT_W-1:0] sub_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       rx_shift;
  logic             dq_fall;
  logic             dq_rise;
  logic             rx_bit;
  logic             rx_push;
  logic [7:0]       rx_push_data;
  logic             stop_hit;
  logic             timeout_hit;

  assign dq_fall      = si_rise & ~tx_busy & dq_last & ~dq_r;
  assign dq_rise      = si_rise & ~tx_busy & ~dq_last & dq_r;
  assign rx_bit       = sub_cnt < CNT_W'(RX_THRESHOLD);
  assign rx_push      = dq_rise && (bit_cnt == 3'd7);
  assign rx_push_data = {rx_shift[6:0], rx_bit};
  assign stop_hit     = si_rise & ~tx_busy & dq_r & ~dq_rise &
                        (sub_cnt == CNT_W'(RX_STOP)) & (bit_cnt == 3'd1);
  // Timeout fires once, on the edge that takes the counter into saturation
  assign timeout_hit  = si_rise & ~tx_busy & dq_r & ~dq_rise &
                        (sub_cnt == CNT_W'(RX_TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dq_last    <= 1'b1;
      sub_cnt    <= '0;
      bit_cnt    <= '0;
      rx_shift   <= '0;
      rx_stop    <= 1'b0;
      rx_timeout <= 1'b0;
    end else begin
      rx_stop    <= 1'b0;
      rx_timeout <= 1'b0;
      if (!con_run) begin
        dq_last <= 1'b1;
        sub_cnt <= '0;
        bit_cnt <= '0;
      end else if (si_rise) begin
        dq_last <= dq_r;
        if (dq_fall) begin
          sub_cnt <= '0;
        end else if (sub_cnt != CNT_W'(RX_TIMEOUT)) begin
          sub_cnt <= sub_cnt + CNT_W'(1);
        end
        if (dq_rise) begin
          rx_shift <= rx_push_data;
          bit_cnt  <= bit_cnt + 3'd1;
        end else if (stop_hit) begin
          rx_stop <= 1'b1;
          bit_cnt <= '0;
        end else if (timeout_hit) begin
          rx_timeout <= 1'b1;
          bit_cnt    <= '0;
        end
      end
    end
  end

  // RX FIFO with registered first-word-fall-through head
  logic [7:0]       rx_mem [RX_FIFO_DEPTH];
  logic [RX_AW-1:0] rx_wp, rx_rp, rx_wp_nxt, rx_rp_nxt;
  logic [RX_CW-1:0] rx_cnt, rx_cnt_nxt;
  logic             rx_pop, rx_full, rx_wr, rx_ovf_set;

  assign rx_pop     = rx_valid & rx_ready;
  assign rx_full    = rx_cnt == RX_CW'(RX_FIFO_DEPTH);
  assign rx_wr      = rx_push & (~rx_full | rx_pop);
  assign rx_ovf_set = rx_push & rx_full & ~rx_pop;

  always_comb begin
    rx_wp_nxt  = rx_wp;
    rx_rp_nxt  = rx_rp;
    rx_cnt_nxt = rx_cnt;
    if (!con_run) begin
      rx_wp_nxt  = '0;
      rx_rp_nxt  = '0;
      rx_cnt_nxt = '0;
    end else begin
      if (rx_pop) rx_rp_nxt = rx_rp + RX_AW'(1);
      if (rx_wr)  rx_wp_nxt = rx_wp + RX_AW'(1);
      rx_cnt_nxt = rx_cnt + RX_CW'(rx_wr) - RX_CW'(rx_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rx_wr) rx_mem[rx_wp] <= rx_push_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_wp       <= '0;
      rx_rp       <= '0;
      rx_cnt      <= '0;
      rx_valid    <= 1'b0;
      rx_data     <= '0;
      rx_overflow <= 1'b0;
    end else begin
      rx_wp    <= rx_wp_nxt;
      rx_rp    <= rx_rp_nxt;
      rx_cnt   <= rx_cnt_nxt;
      rx_valid <= rx_cnt_nxt != '0;
      // Bypass the array when the byte being written becomes the new head
      rx_data  <= (rx_wr && (rx_wp == rx_rp_nxt)) ? rx_push_data : rx_mem[rx_rp_nxt];
      if (rx_ovf_set)             rx_overflow <= 1'b1;
      else if (rx_overflow_clear) rx_overflow <= 1'b0;
    end
  end

  // TX FIFO
  logic [7:0]       tx_mem [TX_FIFO_DEPTH];
  logic [TX_AW-1:0] tx_wp, tx_rp, tx_wp_nxt, tx_rp_nxt;
  logic [TX_CW-1:0] tx_cnt, tx_cnt_nxt;
  logic             tx_push, tx_pop, tx_empty;
  logic [7:0]       tx_head;

  assign tx_push  = tx_valid & tx_ready;
  assign tx_empty = tx_cnt == '0;
  assign tx_head  = tx_mem[tx_rp];

  always_comb begin
    tx_wp_nxt  = tx_wp;
    tx_rp_nxt  = tx_rp;
    tx_cnt_nxt = tx_cnt;
    if (!con_run) begin
      tx_wp_nxt  = '0;
      tx_rp_nxt  = '0;
      tx_cnt_nxt = '0;
    end else begin
      if (tx_pop)  tx_rp_nxt = tx_rp + TX_AW'(1);
      if (tx_push) tx_wp_nxt = tx_wp + TX_AW'(1);
      tx_cnt_nxt = tx_cnt + TX_CW'(tx_push) - TX_CW'(tx_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp] <= tx_data;
  end

  // TX serialiser FSM
  tx_state_t         state_q, state_d;
  logic [TSUB_W-1:0] tx_sub, sub_d;
  logic [2:0]        tx_bit, tbit_d;
  logic [7:0]        tx_shift, shift_d;
  logic              oe_d, done_d, cur_bit;

  assign cur_bit = (state_q == S_STOP) ? 1'b1 : tx_shift[7];

  always_comb begin
    state_d = state_q;
    sub_d   = tx_sub;
    tbit_d  = tx_bit;
    shift_d = tx_shift;
    oe_d    = si_dq_oe;
    done_d  = 1'b0;
    tx_pop  = 1'b0;
    if (!con_run) begin
      state_d = S_IDLE;
      sub_d   = '0;
      tbit_d  = '0;
      oe_d    = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (tx_start) begin
            sub_d  = '0;
            tbit_d = '0;
            if (!tx_empty) begin
              state_d = S_BYTE;
              shift_d = tx_head;
              tx_pop  = 1'b1;
            end else begin
              state_d = S_STOP;
            end
          end
        end
        S_BYTE, S_STOP: begin
          if (si_fall) begin
            oe_d = tx_sub < (cur_bit ? TSUB_W'(TX_ONE_LOW) : TSUB_W'(TX_ZERO_LOW));
            if (tx_sub == TSUB_W'(TX_SUB_BITS - 1)) begin
              sub_d = '0;
              if (state_q == S_STOP) begin
                state_d = S_IDLE;
                done_d  = 1'b1;
              end else if (tx_bit == 3'd7) begin
                tbit_d = '0;
                if (!tx_empty) begin
                  shift_d = tx_head;
                  tx_pop  = 1'b1;
                end else begin
                  state_d = S_STOP;
                end
              end else begin
                tbit_d  = tx_bit + 3'd1;
                shift_d = {tx_shift[6:0], 1'b0};
              end
            end else begin
              sub_d = tx_sub + TSUB_W'(1);
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      tx_sub   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      si_dq_oe <= 1'b0;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
      tx_ready <= 1'b0;
      tx_wp    <= '0;
      tx_rp    <= '0;
      tx_cnt   <= '0;
    end else begin
      state_q  <= state_d;
      tx_sub   <= sub_d;
      tx_bit   <= tbit_d;
      tx_shift <= shift_d;
      si_dq_oe <= oe_d;
      tx_busy  <= state_d != S_IDLE;
      tx_done  <= done_d;
      tx_ready <= (tx_cnt_nxt != TX_CW'(TX_FIFO_DEPTH)) && (state_d == S_IDLE);
      tx_wp    <= tx_wp_nxt;
      tx_rp    <= tx_rp_nxt;
      tx_cnt   <= tx_cnt_nxt;
    end
  end

endmodule

// File: doc/n64_joybus_phy.md
N64_JOYBUS_PHY -- requirements
Module: n64_joybus_phy

Interface
REQ-001 SHALL have parameter RX_FIFO_DEPTH, default 16, RX byte FIFO entries (power of 2, >=2).
REQ-002 SHALL have parameter TX_FIFO_DEPTH, default 16, TX byte FIFO entries (power of 2, >=2).
REQ-003 SHALL have parameter TX_SUB_BITS, default 8, si_clk periods per transmitted bit.
REQ-004 SHALL have parameters TX_ONE_LOW / TX_ZERO_LOW, defaults 2 / 6, low sub-bits for a 1 / 0 bit.
REQ-005 SHALL have parameters RX_THRESHOLD / RX_STOP / RX_TIMEOUT, defaults 4 / 15 / 31, in si_clk rising edges.
REQ-006 SHALL have ports: clk  in  1  system clock; reset  in  1  asynchronous, active-low.
REQ-007 SHALL have ports: n64_reset  in  1  console reset (low = console in reset); n64_si_clk  in  1  async SI clock.
REQ-008 SHALL have ports: si_dq_in  in  1  async DQ level; si_dq_oe  out  1  high = drive DQ low.
REQ-009 SHALL have ports: rx_valid  out  1;  rx_data  out  8;  rx_ready  in  1  RX stream, first-word-fall-through.
REQ-010 SHALL have ports: rx_stop  out  1  frame-end pulse;  rx_timeout  out  1  idle pulse;  rx_overflow  out  1  sticky;  rx_overflow_clear  in  1.
REQ-011 SHALL have ports: tx_valid  in  1;  tx_data  in  8;  tx_ready  out  1  TX stream.
REQ-012 SHALL have ports: tx_start  in  1  pulse;  tx_busy  out  1;  tx_done  out  1  pulse.

Function
REQ-013 SHALL synchronise n64_reset and n64_si_clk via 2 flops, register si_dq_in once; si_clk edges valid only while synchronised n64_reset high.
REQ-014 SHALL sample DQ only on si_clk rising edges; DQ falling/rising edge = change versus last sample, suppressed while tx_busy.
REQ-015 SHALL keep sub-bit counter: cleared on DQ falling edge, else +1 per si_clk rising edge, saturating at RX_TIMEOUT.
REQ-016 SHALL decode a bit on DQ rising edge: 1 if counter < RX_THRESHOLD, else 0; MSB first into shift register.
REQ-017 SHALL push byte into RX FIFO on 8th bit; 3-bit bit counter wraps to 0.
REQ-018 SHALL pulse rx_stop 1 clk when DQ high, counter == RX_STOP and bit counter == 1 (lone stop bit); bit counter cleared.
REQ-019 SHALL pulse rx_timeout 1 clk when DQ high and counter saturated on a rising edge; bit counter cleared; partial byte discarded.
REQ-020 SHALL drop byte and set rx_overflow when RX FIFO full at push; pop in same clk frees space (push accepted).
REQ-021 SHALL clear rx_overflow on rx_overflow_clear; simultaneous set wins.
REQ-022 SHALL pop RX on rx_valid && rx_ready; rx_data stable while rx_valid && !rx_ready.
REQ-023 SHALL accept TX byte on tx_valid && tx_ready; tx_ready = !full && !tx_busy.
REQ-024 SHALL use TX FSM IDLE -> BYTE -> STOP -> IDLE; tx_start in IDLE (n64_reset high) enters BYTE if FIFO non-empty, else STOP; tx_start while busy ignored.
REQ-025 SHALL update si_dq_oe only on si_clk falling edges: per bit, low for TX_ONE_LOW (1) or TX_ZERO_LOW (0) sub-bits, then released for remainder of TX_SUB_BITS.
REQ-026 SHALL pop next byte after 8th bit; go to STOP when FIFO empty; STOP sends one 1-bit.
REQ-027 SHALL pulse tx_done 1 clk and drop tx_busy on STOP completion; tx_busy high from tx_start clk+1.
REQ-028 SHALL, on n64_reset falling mid-operation, release DQ, return FSM to IDLE, flush both FIFOs, clear bit/sub-bit counters; no tx_done.

Reset
REQ-029 SHALL on reset low: si_dq_oe=0, rx_valid=0, rx_stop=0, rx_timeout=0, rx_overflow=0, tx_ready=0 then 1 after release, tx_busy=0, tx_done=0, FIFOs empty, FSM IDLE.
REQ-030 SHALL apply reset asynchronously on assertion; outputs settle without clk.

Verification
REQ-031 SHALL bench: RX bits 0x00 (low 6 sub-bits ×8) then stop bit -> rx_data=0x00, rx_stop one pulse after 15 high edges.
REQ-032 SHALL bench: RX 17 bytes 0xA5..., rx_ready=0 -> 16 held, rx_overflow=1, 17th lost; clear -> 0.
REQ-033 SHALL bench: push 0x80,0x01, tx_start -> DQ low 2/6 sub-bits pattern, then stop bit, tx_done after 17×8 falling edges.
REQ-034 SHALL bench: tx_start with empty FIFO -> only stop bit, tx_done after 8 falling edges.
REQ-035 SHALL bench: n64_reset low during 2nd TX byte -> si_dq_oe=0 within 3 clk, FIFOs empty, no tx_done.
REQ-036 SHALL bench: 3 RX bits then DQ high 31 edges -> rx_timeout pulse, next 8 bits form clean byte.
